// File: rtl/led_blink_pkg.sv
// Shared constants for the LED blink controller: mode encoding and burst-count width.
// The BURST feature is compiled in only when LED_BLINK_BURST_EN is defined.
package led_blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_BURST = 2'b11
    } mode_e;

    localparam int BURST_W = 8;

    function automatic logic mode_is_busy(input mode_e m);
        return (m == MODE_BLINK) || (m == MODE_BURST);
    endfunction

endpackage

// File: rtl/led_blink_chan.sv
// One LED channel: mode state, half-period counter and (with LED_BLINK_BURST_EN) the burst count.
// A write always wins over a coincident tick.
module led_blink_chan
    import led_blink_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               we_i,
    input  logic               tick_i,
    input  logic [1:0]         mode_i,
    input  logic [CNT_W-1:0]   half_i,
`ifdef LED_BLINK_BURST_EN
    input  logic [BURST_W-1:0] burst_i,
    output logic               done_o,
`endif
    output logic               led_o,
    output mode_e              state_o
);

    mode_e              state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   half_q;
    logic               led_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               wrap_d;
`ifdef LED_BLINK_BURST_EN
    logic [BURST_W-1:0] rem_q;
    logic               done_q;
`endif

    // The counter never passes half-1: it clears on the tick that reaches it.
    always_comb begin
        wrap_d = (cnt_q == (half_q - 1'b1));
        cnt_d  = wrap_d ? '0 : (cnt_q + 1'b1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= MODE_OFF;
            cnt_q   <= '0;
            half_q  <= CNT_W'(1);
            led_q   <= 1'b1;
`ifdef LED_BLINK_BURST_EN
            rem_q   <= '0;
            done_q  <= 1'b0;
`endif
        end else begin
`ifdef LED_BLINK_BURST_EN
            done_q <= 1'b0;
`endif
            if (we_i) begin
`ifdef LED_BLINK_BURST_EN
                state_q <= mode_e'(mode_i);
                rem_q   <= burst_i;
`else
                state_q <= (mode_i == MODE_BURST) ? MODE_BLINK : mode_e'(mode_i);
`endif
                half_q  <= (half_i == '0) ? CNT_W'(1) : half_i;
                cnt_q   <= '0;
                led_q   <= (mode_i != MODE_OFF);
            end else begin
                case (state_q)
                    MODE_BLINK: begin
                        if (tick_i) begin
                            cnt_q <= cnt_d;
                            if (wrap_d) led_q <= ~led_q;
                        end
                    end
`ifdef LED_BLINK_BURST_EN
                    MODE_BURST: begin
                        if (rem_q == '0) begin
                            state_q <= MODE_OFF;
                            led_q   <= 1'b0;
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                        end else if (tick_i) begin
                            cnt_q <= cnt_d;
                            if (wrap_d) begin
                                led_q <= ~led_q;
                                // A falling toggle closes one on/off period.
                                if (led_q) begin
                                    rem_q <= rem_q - 1'b1;
                                    if (rem_q == BURST_W'(1)) begin
                                        state_q <= MODE_OFF;
                                        cnt_q   <= '0;
                                        done_q  <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign led_o   = led_q;
    assign state_o = state_q;
`ifdef LED_BLINK_BURST_EN
    assign done_o  = done_q;
`endif

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED blink controller: shared prescaler, write decode, NUM_CH channel instances.
// Define LED_BLINK_BURST_EN to enable BURST mode; otherwise mode 11 runs as BLINK and done is 0.
module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16,
    parameter int PRESC_MAX = 100,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [1:0]         cfg_mode,
    input  logic [CNT_W-1:0]   cfg_half,
    input  logic [BURST_W-1:0] cfg_burst,
    output logic [NUM_CH-1:0]  led_out,
    output logic [NUM_CH-1:0]  busy,
    output logic [NUM_CH-1:0]  done
);

    localparam int PW = (PRESC_MAX > 1) ? $clog2(PRESC_MAX) : 1;

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;
    mode_e         chan_state [NUM_CH];

    always_comb begin
        tick    = (presc_q == PW'(PRESC_MAX - 1));
        presc_d = tick ? '0 : (presc_q + 1'b1);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) presc_q <= '0;
        else         presc_q <= presc_d;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic we_ch;
        // Channel numbers at or above NUM_CH match no instance and are dropped.
        assign we_ch = cfg_we && (cfg_ch == CH_W'(i));

        led_blink_chan #(.CNT_W(CNT_W)) u_chan (
            .clk_i   (sys_clk),
            .rst_i   (sys_rst),
            .we_i    (we_ch),
            .tick_i  (tick),
            .mode_i  (cfg_mode),
            .half_i  (cfg_half),
`ifdef LED_BLINK_BURST_EN
            .burst_i (cfg_burst),
            .done_o  (done[i]),
`endif
            .led_o   (led_out[i]),
            .state_o (chan_state[i])
        );

        assign busy[i] = mode_is_busy(chan_state[i]);
    end

`ifndef LED_BLINK_BURST_EN
    logic unused_burst;
    assign unused_burst = ^cfg_burst;
    assign done = '0;
`endif

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl with NUM_CH=4, PRESC_MAX=4 (tick edges are edge_n % 4 == 0).
// BURST checks are built when LED_BLINK_BURST_EN is defined; otherwise mode 11 is checked as BLINK.
module tb_led_blink_ctrl;
    import led_blink_pkg::*;

    localparam int NUM_CH    = 4;
    localparam int CNT_W     = 16;
    localparam int PRESC_MAX = 4;

    logic              sys_clk;
    logic              sys_rst;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [1:0]        cfg_mode;
    logic [CNT_W-1:0]  cfg_half;
    logic [7:0]        cfg_burst;
    logic [NUM_CH-1:0] led_out;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;

    int n_cmp  = 0;
    int n_err  = 0;
    int edge_n = 0;
    int done_total = 0;

    led_blink_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_MAX(PRESC_MAX)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_half  (cfg_half),
        .cfg_burst (cfg_burst),
        .led_out   (led_out),
        .busy      (busy),
        .done      (done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) edge_n <= 0;
        else         edge_n <= edge_n + 1;
    end

    always @(negedge sys_clk) begin
        if (!sys_rst && done != '0) done_total <= done_total + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the write edge with w_edge = that edge.
    task automatic do_write(input int ch, input logic [1:0] mode, input int half,
                            input int burst, output int w_edge);
        cfg_we    = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_mode  = mode;
        cfg_half  = CNT_W'(half);
        cfg_burst = 8'(burst);
        @(posedge sys_clk);
        @(negedge sys_clk);
        cfg_we = 1'b0;
        w_edge = edge_n;
    endtask

    task automatic align(input int phase);
        for (int i = 0; i < 8; i++) begin
            if (edge_n % 4 == phase) break;
            @(negedge sys_clk);
        end
    endtask

    task automatic wait_toggle(input int ch, input int bound, output int at);
        logic prev;
        prev = led_out[ch];
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge sys_clk);
            if (led_out[ch] !== prev) begin
                at = edge_n;
                break;
            end
        end
    endtask

    initial begin
        int w, t, t2, bad;
        sys_rst   = 1'b1;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_mode  = '0;
        cfg_half  = '0;
        cfg_burst = '0;

        repeat (3) @(negedge sys_clk);
        check_eq("rst_led", 32'(led_out), 32'hf);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        sys_rst = 1'b0;

        bad = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (led_out !== 4'hf || busy !== 4'h0 || done !== 4'h0) bad++;
        end
        check_eq("idle_hold_bad_cycles", 32'(bad), 0);
        check_eq("idle_led", 32'(led_out), 32'hf);

        // ch0 BLINK half=3, written one edge after a tick edge: toggles on the 3rd tick
        align(0);
        do_write(0, MODE_BLINK, 3, 0, w);
        check_eq("blink_led_on", 32'(led_out[0]), 1);
        check_eq("blink_busy", 32'(busy[0]), 1);
        wait_toggle(0, 40, t);
        check_eq("blink_first_toggle", 32'(t), 32'(w + 11));

        do_write(3, MODE_ON, 5, 0, w);
        check_eq("on_led", 32'(led_out[3]), 1);
        check_eq("on_busy", 32'(busy[3]), 0);
        do_write(3, MODE_OFF, 5, 0, w);
        check_eq("off_led", 32'(led_out[3]), 0);
        wait_toggle(0, 40, t2);
        check_eq("blink_period_after_other_writes", 32'(t2 - t), 12);
        wait_toggle(0, 40, t);
        check_eq("blink_period2", 32'(t - t2), 12);
        check_eq("off_hold_led", 32'(led_out[3]), 0);
        check_eq("off_hold_busy", 32'(busy[3]), 0);

        // Write on a tick edge: that tick is ignored, counter starts from 0
        align(3);
        do_write(2, MODE_BLINK, 2, 0, w);
        check_eq("tickwr_led", 32'(led_out[2]), 1);
        wait_toggle(2, 40, t);
        check_eq("tickwr_toggle", 32'(t), 32'(w + 8));

        align(3);
        do_write(2, MODE_BLINK, 0, 0, w);
        check_eq("half0_led", 32'(led_out[2]), 1);
        wait_toggle(2, 20, t);
        check_eq("half0_toggle1", 32'(t), 32'(w + 4));
        wait_toggle(2, 20, t);
        check_eq("half0_toggle2", 32'(t), 32'(w + 8));

`ifdef LED_BLINK_BURST_EN
        begin
            int falls, dn, dn_at;
            logic prev;
            align(0);
            do_write(1, MODE_BURST, 2, 3, w);
            check_eq("burst_led_on", 32'(led_out[1]), 1);
            check_eq("burst_busy", 32'(busy[1]), 1);
            falls = 0; dn = 0; dn_at = -1;
            prev = led_out[1];
            repeat (50) begin
                @(negedge sys_clk);
                if (prev && !led_out[1]) falls++;
                if (done[1]) begin dn++; dn_at = edge_n; end
                prev = led_out[1];
            end
            check_eq("burst_pulses", 32'(falls), 3);
            check_eq("burst_done_count", 32'(dn), 1);
            check_eq("burst_done_edge", 32'(dn_at), 32'(w + 39));
            check_eq("burst_end_led", 32'(led_out[1]), 0);
            check_eq("burst_end_busy", 32'(busy[1]), 0);

            do_write(1, MODE_BURST, 2, 0, w);
            check_eq("burst0_done_early", 32'(done[1]), 0);
            @(negedge sys_clk);
            check_eq("burst0_led", 32'(led_out[1]), 0);
            check_eq("burst0_done", 32'(done[1]), 1);
            check_eq("burst0_busy", 32'(busy[1]), 0);
            @(negedge sys_clk);
            check_eq("burst0_done_once", 32'(done[1]), 0);

            do_write(2, MODE_BURST, 1, 5, w);
            repeat (6) @(negedge sys_clk);
            align(0);
            do_write(2, MODE_BLINK, 1, 0, w);
            wait_toggle(2, 10, t);
            check_eq("abort_new_blink_toggle", 32'(t), 32'(w + 3));
            dn = 0;
            repeat (30) begin
                @(negedge sys_clk);
                if (done[2]) dn++;
            end
            check_eq("abort_no_done", 32'(dn), 0);
            check_eq("abort_busy", 32'(busy[2]), 1);

            do_write(1, MODE_BURST, 2, 5, w);
            repeat (5) @(negedge sys_clk);
        end
`else
        align(0);
        do_write(1, MODE_BURST, 2, 3, w);
        check_eq("m11_busy", 32'(busy[1]), 1);
        check_eq("m11_led", 32'(led_out[1]), 1);
        wait_toggle(1, 20, t);
        check_eq("m11_toggle1", 32'(t), 32'(w + 7));
        wait_toggle(1, 20, t);
        check_eq("m11_toggle2", 32'(t), 32'(w + 15));
        repeat (60) @(negedge sys_clk);
        check_eq("m11_still_busy", 32'(busy[1]), 1);
        check_eq("m11_done_total", 32'(done_total), 0);
`endif

        // Asynchronous reset while channels are active
        @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        check_eq("midrst_led", 32'(led_out), 32'hf);
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_done", 32'(done), 0);
        bad = 0;
        repeat (2) begin
            @(negedge sys_clk);
            if (done !== 4'h0) bad++;
        end
        sys_rst = 1'b0;
        repeat (12) begin
            @(negedge sys_clk);
            if (done !== 4'h0 || led_out !== 4'hf) bad++;
        end
        check_eq("postrst_hold_bad_cycles", 32'(bad), 0);
        check_eq("postrst_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_blink_ctrl.md
LED_BLINK_CTRL -- requirements
Module: led_blink_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent LED channels (1..16).
REQ-002 Parameter CNT_W, default 16: width of the per-channel half-period counter.
REQ-003 Parameter PRESC_MAX, default 100: sys_clk cycles per prescaler tick (>=1).
REQ-004 sys_clk  input  1  single clock; all state on rising edge.
REQ-005 sys_rst  input  1  reset, asynchronous, active-high.
REQ-006 cfg_we  input  1  configuration write strobe, always accepted, one write per cycle.
REQ-007 cfg_ch  input  max(1,clog2(NUM_CH))  target channel; writes with cfg_ch>=NUM_CH are ignored.
REQ-008 cfg_mode  input  2  00 OFF, 01 ON, 10 BLINK, 11 BURST.
REQ-009 cfg_half  input  CNT_W  half-period in ticks; 0 treated as 1.
REQ-010 cfg_burst  input  8  number of on/off periods for BURST.
REQ-011 led_out  output  NUM_CH  LED drive, one bit per channel.
REQ-012 busy  output  NUM_CH  channel is in BLINK or an unfinished BURST.
REQ-013 done  output  NUM_CH  one-cycle pulse when a BURST completes.

Function
REQ-014 Shared prescaler SHALL count 0..PRESC_MAX-1 and assert tick for one cycle when the count equals PRESC_MAX-1, then wrap to 0.
REQ-015 A write SHALL take effect on the next edge: mode/half/burst latched, channel counter cleared, led_out set to 0 (OFF), 1 (ON, BLINK, BURST).
REQ-016 Write and tick on the same cycle for the same channel: the write SHALL win and the tick SHALL be ignored for that channel.
REQ-017 BLINK: on each tick the counter SHALL increment; on a tick with counter==half-1, the counter SHALL clear and led_out SHALL toggle; period = 2*half*PRESC_MAX cycles.
REQ-018 BURST: toggling SHALL follow BLINK timing, and the remaining count SHALL decrement on each 0-going toggle.
REQ-019 BURST: when remaining reaches 0, the channel SHALL enter the OFF state (led_out 0, busy 0) and pulse done for exactly one cycle.
REQ-020 BURST with cfg_burst=0 SHALL complete on the cycle after the write (led_out 0, done pulse, no lit phase beyond that cycle).
REQ-021 A write to a busy channel SHALL abort it silently (no done pulse), and the new configuration SHALL start.
REQ-022 OFF/ON: counters SHALL hold at 0; busy SHALL be 0; ticks SHALL have no effect.
REQ-023 Channels SHALL be fully independent; a write to one SHALL NOT disturb the phase of the others.
REQ-024 The counter arithmetic SHALL be CNT_W bits, unsigned, and SHALL never exceed half-1.

Reset
REQ-025 While sys_rst is high: prescaler 0, all channel counters 0, mode OFF, led_out all ones, busy 0, done 0.
REQ-026 After reset deassertion, led_out SHALL stay all ones until the first write to each channel.
REQ-027 Reset asserted mid-BURST SHALL abort it with no done pulse.

Configuration
REQ-028 With the macro LED_BLINK_BURST_EN defined, BURST mode SHALL operate as specified.
REQ-029 Without LED_BLINK_BURST_EN, mode 11 SHALL behave as BLINK, done SHALL be constant 0, and the burst counter logic SHALL be absent.

Structure
REQ-030 Package led_blink_pkg SHALL hold the mode encoding constants (MODE_OFF, MODE_ON, MODE_BLINK, MODE_BURST) and the burst-count width constant.
REQ-031 Sub-module led_blink_chan SHALL implement one channel (counter, mode state, burst count) and SHALL be instantiated NUM_CH times.
REQ-032 The prescaler and the write decode SHALL reside in the top level.

Verification
REQ-033 Reset with NUM_CH=4, then release and no writes -> led_out=4'b1111, busy=0, done=0 indefinitely.
REQ-034 PRESC_MAX=4, write ch0 BLINK half=3 -> led_out[0] toggles every 12 cycles, busy[0]=1.
REQ-035 Write ch1 BURST half=2 burst=3 -> exactly 3 high pulses, then led_out[1]=0, one done[1] pulse, busy[1]=0.
REQ-036 BURST burst=0 -> done pulse on the next cycle, with no extended high phase; write ch2 during a BURST -> no done pulse, new mode active.
REQ-037 Write coinciding with tick, and cfg_half=0 -> counter restarts from 0; half=0 toggles every tick.
REQ-038 sys_rst asserted mid-BURST -> outputs immediately reset values, no done; build without LED_BLINK_BURST_EN, mode 11 -> plain BLINK, done stays 0.
